// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the write-back stage.
package wb_stage_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Architectural zero register: never written, never forwarded.
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

  // One pending result in the write-back queue.
  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Execute/regfile/decode-facing signal bundle of the write-back stage.
interface wb_stage_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     ex_valid;
  logic                     ex_ready;
  logic                     ex_wen;
  logic [ADDR_W-1:0]        ex_waddr;
  logic [DATA_W-1:0]        ex_wdata;
  logic                     flush;
  logic                     rf_hold;
  logic                     rf_write;
  logic [ADDR_W-1:0]        rf_waddr;
  logic [DATA_W-1:0]        rf_wdata;
  logic [ADDR_W-1:0]        rd_addr1;
  logic [ADDR_W-1:0]        rd_addr2;
  logic                     fwd1_hit;
  logic [DATA_W-1:0]        fwd1_data;
  logic                     fwd2_hit;
  logic [DATA_W-1:0]        fwd2_data;
  logic [$clog2(DEPTH):0]   occupancy;

  // Surrounding pipeline side.
  modport master (
    output ex_valid, ex_wen, ex_waddr, ex_wdata, flush, rf_hold, rd_addr1, rd_addr2,
    input  ex_ready, rf_write, rf_waddr, rf_wdata, fwd1_hit, fwd1_data,
           fwd2_hit, fwd2_data, occupancy
  );

  // Write-back stage side.
  modport slave (
    input  ex_valid, ex_wen, ex_waddr, ex_wdata, flush, rf_hold, rd_addr1, rd_addr2,
    output ex_ready, rf_write, rf_waddr, rf_wdata, fwd1_hit, fwd1_data,
           fwd2_hit, fwd2_data, occupancy
  );
endinterface

// File: rtl/wb_stage_fwd_match.sv
// Youngest-match search over the pending-result queue for one read port.
module wb_fwd_match
  import wb_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t [DEPTH-1:0] ent_i,
  input  logic [PTR_W-1:0]      tail_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk from the slot just behind tail (youngest) toward head; first match wins.
  always_comb begin
    found  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      idx = tail_i - PTR_W'(k);
      if (!found && ent_i[idx].valid && ent_i[idx].waddr == rd_addr_i &&
          rd_addr_i != REG_ZERO) begin
        found  = 1'b1;
        data_o = ent_i[idx].wdata;
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: in-order result queue draining into the regfile write port,
// with youngest-match forwarding to decode.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_stage_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic full, empty, pop, enq;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // No pop-through: a full queue refuses even when the head drains this cycle.
  assign bus.ex_ready  = !full;
  assign pop           = !empty && !bus.rf_hold && !bus.flush;
  assign bus.rf_write  = pop;
  assign bus.rf_waddr  = empty ? '0 : ent_q[head_q].waddr;
  assign bus.rf_wdata  = empty ? '0 : ent_q[head_q].wdata;
  assign bus.occupancy = count_q;

  // Accepted transfers with no architectural effect complete the handshake only.
  assign enq = bus.ex_valid && !full && !bus.flush && bus.ex_wen &&
               (bus.ex_waddr != REG_ZERO);

  // Next-state for queue storage, pointers and count; flush dominates.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        ent_d[head_q].valid = 1'b0;
        head_d = head_q + PTR_W'(1);
      end
      if (enq) begin
        ent_d[tail_q] = '{valid: 1'b1, waddr: bus.ex_waddr, wdata: bus.ex_wdata};
        tail_d = tail_q + PTR_W'(1);
      end
      case ({enq, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; reset drops every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
    .ent_i(ent_q), .tail_i(tail_q), .rd_addr_i(bus.rd_addr1),
    .hit_o(bus.fwd1_hit), .data_o(bus.fwd1_data)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd2 (
    .ent_i(ent_q), .tail_i(tail_q), .rd_addr_i(bus.rd_addr2),
    .hit_o(bus.fwd2_hit), .data_o(bus.fwd2_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_stage_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();

  wb_stage #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl, input logic hold,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus.ex_valid = v;  bus.ex_wen = wen; bus.ex_waddr = wa; bus.ex_wdata = wd;
    bus.flush = fl;    bus.rf_hold = hold; bus.rd_addr1 = r1; bus.rd_addr2 = r2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges; called right after edge_().
  task automatic pulse_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    edge_();
  endtask

  typedef struct {
    logic v, wen; logic [4:0] wa; logic [31:0] wd; logic fl, hold; logic [4:0] r1, r2;
    logic e_rdy, e_wr; logic [4:0] e_wa; logic [31:0] e_wd;
    logic e_h1; logic [31:0] e_d1; logic e_h2; logic [31:0] e_d2; logic [2:0] e_occ;
  } vec_t;

  vec_t vec [10];

  // Reference model: pending results as a plain in-order list.
  typedef struct { logic [4:0] a; logic [31:0] d; } pend_t;
  pend_t mq[$];

  task automatic model_fwd(input logic [4:0] rd, output logic hit, output logic [31:0] d);
    hit = 1'b0; d = '0;
    if (rd != 0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (!hit && mq[i].a == rd) begin hit = 1'b1; d = mq[i].d; end
  endtask

  task automatic model_check_and_step();
    logic e_rdy, e_wr, h1, h2; logic [31:0] d1, d2;
    e_rdy = (mq.size() != DEPTH);
    e_wr  = (mq.size() != 0) && !bus.rf_hold && !bus.flush;
    model_fwd(bus.rd_addr1, h1, d1);
    model_fwd(bus.rd_addr2, h2, d2);
    chk("rnd_ready", bus.ex_ready, e_rdy);
    chk("rnd_write", bus.rf_write, e_wr);
    chk("rnd_waddr", bus.rf_waddr, mq.size() != 0 ? mq[0].a : 5'd0);
    chk("rnd_wdata", bus.rf_wdata, mq.size() != 0 ? mq[0].d : 32'd0);
    chk("rnd_fwd1", {bus.fwd1_hit, bus.fwd1_data}, {h1, d1});
    chk("rnd_fwd2", {bus.fwd2_hit, bus.fwd2_data}, {h2, d2});
    chk("rnd_occ", bus.occupancy, mq.size());
    if (bus.flush) mq.delete();
    else begin
      if (e_wr) void'(mq.pop_front());
      if (bus.ex_valid && e_rdy && bus.ex_wen && bus.ex_waddr != 0)
        mq.push_back('{a: bus.ex_waddr, d: bus.ex_wdata});
    end
    edge_();
  endtask

  initial begin
    //        v  wen wa  wd            fl hold r1 r2 | rdy wr wa  wd            h1 d1            h2 d2  occ
    vec[0] = '{0, 0, 0,  32'h0,        0, 0,   5, 0,   1,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0};
    vec[1] = '{1, 1, 8,  32'hDEADBEEF, 0, 0,   8, 0,   1,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0};
    vec[2] = '{0, 0, 0,  32'h0,        0, 0,   8, 0,   1,  1, 8,  32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0, 1};
    vec[3] = '{1, 1, 5,  32'd11,       0, 1,   5, 0,   1,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0};
    vec[4] = '{1, 1, 5,  32'd22,       0, 1,   5, 0,   1,  0, 5,  32'd11,       1, 32'd11,       0, 32'h0, 1};
    vec[5] = '{0, 0, 0,  32'h0,        0, 1,   5, 0,   1,  0, 5,  32'd11,       1, 32'd22,       0, 32'h0, 2};
    vec[6] = '{1, 1, 0,  32'd7,        0, 0,   5, 0,   1,  1, 5,  32'd11,       1, 32'd22,       0, 32'h0, 2};
    vec[7] = '{1, 0, 3,  32'd9,        0, 0,   5, 3,   1,  1, 5,  32'd22,       1, 32'd22,       0, 32'h0, 1};
    vec[8] = '{0, 0, 0,  32'h0,        0, 0,   5, 3,   1,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0};
    vec[9] = '{0, 0, 0,  32'h0,        0, 0,   0, 8,   1,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0, 0};

    idle();
    #3;
    chk("rst_ready", bus.ex_ready, 1);
    chk("rst_write", bus.rf_write, 0);
    chk("rst_wbus", {bus.rf_waddr, bus.rf_wdata}, 0);
    chk("rst_fwd", {bus.fwd1_hit, bus.fwd1_data, bus.fwd2_hit, bus.fwd2_data}, 0);
    chk("rst_occ", bus.occupancy, 0);
    #9 rst_n = 1'b1;
    edge_();

    // Vector table: single write, youngest forwarding, zero-register / no-write.
    for (int i = 0; i < 10; i++) begin
      drive(vec[i].v, vec[i].wen, vec[i].wa, vec[i].wd, vec[i].fl, vec[i].hold,
            vec[i].r1, vec[i].r2);
      #1;
      chk($sformatf("vec%0d_ready", i), bus.ex_ready, vec[i].e_rdy);
      chk($sformatf("vec%0d_write", i), bus.rf_write, vec[i].e_wr);
      chk($sformatf("vec%0d_wbus", i), {bus.rf_waddr, bus.rf_wdata}, {vec[i].e_wa, vec[i].e_wd});
      chk($sformatf("vec%0d_fwd1", i), {bus.fwd1_hit, bus.fwd1_data}, {vec[i].e_h1, vec[i].e_d1});
      chk($sformatf("vec%0d_fwd2", i), {bus.fwd2_hit, bus.fwd2_data}, {vec[i].e_h2, vec[i].e_d2});
      chk($sformatf("vec%0d_occ", i), bus.occupancy, vec[i].e_occ);
      edge_();
    end

    // Fill and stall, refused fifth push, in-order drain.
    pulse_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 1, 5'(i), 32'(100 + i), 0, 1, 0, 0);
      edge_();
    end
    drive(1, 1, 5'd9, 32'd999, 0, 1, 9, 0);
    #1;
    chk("fill_ready", bus.ex_ready, 0);
    chk("fill_occ", bus.occupancy, 4);
    edge_();
    chk("fill_refused_occ", bus.occupancy, 4);
    chk("fill_refused_fwd", bus.fwd1_hit, 0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("drain%0d_write", i), bus.rf_write, 1);
      chk($sformatf("drain%0d_wbus", i), {bus.rf_waddr, bus.rf_wdata}, {5'(i), 32'(100 + i)});
      edge_();
    end
    chk("drain_done_write", bus.rf_write, 0);
    chk("drain_done_occ", bus.occupancy, 0);

    // Flush with concurrent push.
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 5'(i), 32'(200 + i), 0, 1, 0, 0);
      edge_();
    end
    drive(1, 1, 5'd7, 32'd777, 1, 0, 7, 1);
    #1;
    chk("flush_cyc_write", bus.rf_write, 0);
    chk("flush_cyc_occ", bus.occupancy, 3);
    edge_();
    drive(0, 0, 0, 0, 0, 0, 7, 1);
    #1;
    chk("flush_occ", bus.occupancy, 0);
    chk("flush_write", bus.rf_write, 0);
    chk("flush_fwd", {bus.fwd1_hit, bus.fwd2_hit}, 0);
    edge_();
    chk("flush_dropped_occ", bus.occupancy, 0);

    // Asynchronous reset mid-drain.
    for (int i = 1; i <= 2; i++) begin
      drive(1, 1, 5'(10 + i), 32'(300 + i), 0, 1, 0, 0);
      edge_();
    end
    drive(0, 0, 0, 0, 0, 0, 11, 12);
    #1;
    chk("arst_pre_write", bus.rf_write, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_write", bus.rf_write, 0);
    chk("arst_occ", bus.occupancy, 0);
    chk("arst_ready", bus.ex_ready, 1);
    chk("arst_fwd", {bus.fwd1_hit, bus.fwd2_hit}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      edge_();
      chk("arst_after_write", bus.rf_write, 0);
      chk("arst_after_occ", bus.occupancy, 0);
    end

    // Randomized traffic against the reference model.
    pulse_reset();
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)),
            $urandom, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 35,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      #1;
      model_check_and_step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the register-file interface. The execute side already drives the register file's read side and leaves its write port unconnected; this block owns that write port.
- Accepts completed results from execute through a valid/ready handshake and buffers them in a small in-order queue.
- Drains one result per cycle into the register-file write port.
- Supplies youngest-match forwarding for the two decode read addresses, so decode sees values still pending in the queue.

Parameters:
- DEPTH, 4, pending-result queue entries (power of two, ≥2)
- DATA_W, 32, result width
- ADDR_W, 5, register address width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ex_valid  input  1  execute presents a result this cycle
- ex_ready  output  1  queue can accept (not full)
- ex_wen  input  1  result writes a register (0 = no architectural write)
- ex_waddr  input  ADDR_W  destination register
- ex_wdata  input  DATA_W  result value
- flush  input  1  discard all pending results
- rf_hold  input  1  register file cannot accept a write this cycle
- rf_write  output  1  register-file write enable
- rf_waddr  output  ADDR_W  register-file write address
- rf_wdata  output  DATA_W  register-file write data
- rd_addr1  input  ADDR_W  decode read address 1
- rd_addr2  input  ADDR_W  decode read address 2
- fwd1_hit  output  1  pending value exists for rd_addr1
- fwd1_data  output  DATA_W  youngest pending value for rd_addr1
- fwd2_hit  output  1  as fwd1_hit, for rd_addr2
- fwd2_data  output  DATA_W  as fwd1_data, for rd_addr2
- occupancy  output  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst_n low, asynchronous):
  - head, tail and count clear to 0; all entry valid bits clear.
  - ex_ready=1, rf_write=0, rf_waddr=0, rf_wdata=0, fwd*_hit=0, fwd*_data=0, occupancy=0.
- Reset in mid-operation loses all pending entries; no partial write is issued.
- Push: occurs on a clk edge when ex_valid && ex_ready && !flush.
  - If ex_wen=0 or ex_waddr=0, the transfer is accepted (handshake completes) but nothing is enqueued. Register 0 is never written.
- ex_ready = (count != DEPTH). There is no pop-through when full: a push in a full cycle is refused even if a pop happens in the same cycle.
- Drain path (combinational from the head entry):
  - rf_write = (count != 0) && !rf_hold && !flush.
  - rf_waddr and rf_wdata come from the head entry; both are 0 when the queue is empty.
  - Pop occurs on the edge where rf_write=1. Latency from push to rf_write is at least 1 cycle: an entry pushed at edge N can be written at edge N+1.
- Simultaneous push and pop: count is unchanged; the pointers each advance.
- Pointer wrap: head and tail wrap modulo DEPTH; count disambiguates full from empty.
- Flush:
  - Takes effect at the next edge and overrides push and pop in the same cycle.
  - After that edge count=0 and all entry valid bits are cleared.
  - rf_write is forced to 0 during the flush cycle.
- Forwarding (combinational):
  - The search covers valid queued entries only; the entry being accepted this cycle is not visible until the following cycle.
  - fwdN_hit=1 when some valid entry has waddr==rd_addrN and rd_addrN != 0.
  - fwdN_data is the value from the youngest matching entry (the one closest to tail).
  - On no hit, fwdN_data=0.
  - The head entry being drained this cycle still counts as a hit.
- Accounting: occupancy = count, exact in every cycle.
- Arithmetic: all data is passed through unmodified; there is no sign extension or truncation.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults.
  - The zero-register constant REG_ZERO=0.
  - The wb_entry_t struct {valid, waddr, wdata}.
- One natural sub-module: wb_fwd_match. It is a combinational youngest-match priority search over the entry array, instantiated twice, once per read port.

Test Plan:
- Single write: push waddr=8, wdata=32'hDEAD_BEEF at edge 1 → at edge 2 rf_write=1, rf_waddr=8, rf_wdata=DEADBEEF; occupancy returns 0 after edge 2.
- Fill and stall: rf_hold=1, push 4 results to r1..r4 → ex_ready=0 and occupancy=4; 5th push is refused. Release rf_hold → writes r1,r2,r3,r4 in order on 4 consecutive edges.
- Forward youngest: queue r5=11, then r5=22, rf_hold=1, rd_addr1=5 → fwd1_hit=1, fwd1_data=22. Set rd_addr2=0 → fwd2_hit=0.
- Zero register / no-write: push waddr=0 with wdata=7, then a push with ex_wen=0 → both handshakes complete, occupancy stays 0, rf_write never asserts.
- Flush with concurrent push: 3 entries queued; assert flush with ex_valid=1 → next cycle occupancy=0, no rf_write during the flush cycle, and the concurrent push is dropped.
- Async reset mid-drain: 2 entries queued and draining; pulse rst_n low between edges → rf_write=0 immediately, occupancy=0, ex_ready=1, no further writes after release.
